// File: rtl/evm_ballot_input_conditioner.sv
// Ballot front-end: syncs and debounces the ready/candidate buttons, then sequences one vote per ready window.
// Optional macro EVM_BALLOT_CNT_EN adds a saturating ballots_issued counter.
module evm_ballot_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        switch_on_evm,
  input  logic        btn_ready_raw,
  input  logic [2:0]  btn_cand_raw,
  output logic        candidate_ready,
  output logic        vote_candidate_1,
  output logic        vote_candidate_2,
  output logic        vote_candidate_3,
  output logic        multi_press_err,
  output logic        timeout_err
`ifdef EVM_BALLOT_CNT_EN
  ,
  output logic [15:0] ballots_issued
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DEB_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_TC  = TW'(TIMEOUT_CYCLES - 1);

  // states: IDLE wait ready | ARMED window open | ISSUE vote pulse | REJECT multi-press held | WAIT_REL wait release
  typedef enum logic [2:0] {IDLE, ARMED, ISSUE, REJECT, WAIT_REL} state_t;

  logic [3:0]    raw;
  logic [3:0]    meta;
  logic [3:0]    sync;
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];
  logic          ready_q;
  logic          ready_rise;
  logic [2:0]    cand;
  logic          cand_none;
  logic          cand_one;
  state_t        state;
  logic [TW-1:0] tcnt;

  // bit 0 is the officer ready button, bits 3:1 are candidates 1..3
  assign raw = {btn_cand_raw, btn_ready_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= '0;
      sync    <= '0;
      deb     <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      meta    <= raw;
      sync    <= meta;
      ready_q <= deb[0];
      for (int i = 0; i < 4; i++) begin
        if (sync[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_TC) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ready_rise = deb[0] & ~ready_q;
  assign cand       = deb[3:1];
  assign cand_none  = (cand == 3'b000);
  assign cand_one   = (cand == 3'b001) || (cand == 3'b010) || (cand == 3'b100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tcnt             <= '0;
      candidate_ready  <= 1'b0;
      vote_candidate_1 <= 1'b0;
      vote_candidate_2 <= 1'b0;
      vote_candidate_3 <= 1'b0;
      multi_press_err  <= 1'b0;
      timeout_err      <= 1'b0;
`ifdef EVM_BALLOT_CNT_EN
      ballots_issued   <= '0;
`endif
    end else begin
      vote_candidate_1 <= 1'b0;
      vote_candidate_2 <= 1'b0;
      vote_candidate_3 <= 1'b0;
      multi_press_err  <= 1'b0;
      timeout_err      <= 1'b0;
      if (!switch_on_evm) begin
        state           <= IDLE;
        candidate_ready <= 1'b0;
        tcnt            <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ready_rise) begin
              if (!cand_none) begin
                state <= WAIT_REL;
              end else begin
                state           <= ARMED;
                candidate_ready <= 1'b1;
                tcnt            <= '0;
              end
            end
          end
          ARMED: begin
            // a valid press beats a coinciding timeout; timeout beats multi-press so tcnt never wraps
            if (cand_one) begin
              state            <= ISSUE;
              candidate_ready  <= 1'b0;
              tcnt             <= '0;
              vote_candidate_1 <= cand[0];
              vote_candidate_2 <= cand[1];
              vote_candidate_3 <= cand[2];
`ifdef EVM_BALLOT_CNT_EN
              if (ballots_issued != 16'hFFFF) ballots_issued <= ballots_issued + 16'd1;
`endif
            end else if (tcnt == TO_TC) begin
              state           <= IDLE;
              candidate_ready <= 1'b0;
              timeout_err     <= 1'b1;
              tcnt            <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
              if (!cand_none) begin
                state           <= REJECT;
                multi_press_err <= 1'b1;
              end
            end
          end
          ISSUE: state <= WAIT_REL;
          REJECT: begin
            if (tcnt == TO_TC) begin
              state           <= IDLE;
              candidate_ready <= 1'b0;
              timeout_err     <= 1'b1;
              tcnt            <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
              if (cand_none) state <= ARMED;
            end
          end
          WAIT_REL: begin
            if (cand_none) state <= IDLE;
          end
          default: begin
            state           <= IDLE;
            candidate_ready <= 1'b0;
            tcnt            <= '0;
          end
        endcase
      end
    end
  end

endmodule
